// File: rtl/tz_secure_fifo_arb.sv
// tz_secure_fifo_arb: round-robin arbitrated multi-channel write FIFO with per-entry security tags
// Non-secure readers never see secure data; violations pulse viol and bump a saturating counter.
module tz_secure_fifo_arb #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8,
    parameter int NUM_CH         = 2,
    parameter int ALLOW_NS_WRITE = 1,
    parameter int CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          wr_valid,
    output logic [NUM_CH-1:0]          wr_ready,
    input  logic [NUM_CH*DATA_W-1:0]   wr_data,
    input  logic [NUM_CH-1:0]          wr_sec,
    input  logic                       rd_req,
    input  logic                       rd_sec,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_sec_out,
    output logic                       rd_err,
    output logic                       viol,
    output logic [CNT_W-1:0]           viol_cnt,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic [DATA_W:0]       mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rr_q, rr_d, gnt;
    logic                  found, grant, push, drop, pop, rviol, full;
    logic                  gsec;
    logic [DATA_W-1:0]     gdata;
    logic [DATA_W:0]       head;
    logic                  rd_valid_q, rd_valid_d, rd_sec_q, rd_sec_d;
    logic                  rd_err_q, rd_err_d, viol_q, viol_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [CNT_W-1:0]      vcnt_q, vcnt_d;
    logic [CNT_W:0]        vsum;

    // First valid channel at or after rr_q, searching with wrap
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int j;
            j = (int'(rr_q) + k) % NUM_CH;
            if (!found && wr_valid[j]) begin
                found = 1'b1;
                gnt   = PW'(j);
            end
        end
    end

    assign full  = count_q == CW'(DEPTH);
    assign grant = found && !full;
    assign gsec  = wr_sec[gnt];
    assign gdata = wr_data[gnt*DATA_W +: DATA_W];
    assign push  = grant && (ALLOW_NS_WRITE != 0 || gsec);
    assign drop  = grant && !push;
    assign pop   = rd_req && count_q != '0;
    assign head  = mem_q[rd_ptr_q];
    assign rviol = pop && head[DATA_W] && !rd_sec;

    always_comb begin
        wr_ready = '0;
        if (grant) wr_ready[gnt] = 1'b1;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rr_d       = !grant ? rr_q : (int'(gnt) == NUM_CH - 1 ? '0 : gnt + 1'b1);
        rd_valid_d = pop;
        rd_err_d   = rviol;
        rd_sec_d   = pop ? head[DATA_W] : rd_sec_q;
        rd_data_d  = !pop ? rd_data_q : (rviol ? '0 : head[DATA_W-1:0]);
        viol_d     = drop || rviol;
        vsum       = {1'b0, vcnt_q} + (CNT_W+1)'(drop) + (CNT_W+1)'(rviol);
        vcnt_d     = vsum[CNT_W] ? '1 : vsum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {gsec, gdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_sec_q   <= 1'b0;
            rd_data_q  <= '0;
            viol_q     <= 1'b0;
            vcnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_sec_q   <= rd_sec_d;
            rd_data_q  <= rd_data_d;
            viol_q     <= viol_d;
            vcnt_q     <= vcnt_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_sec_out = rd_sec_q;
    assign rd_err     = rd_err_q;
    assign viol       = viol_q;
    assign viol_cnt   = vcnt_q;
    assign count      = count_q;
endmodule
